// File: rtl/twiddle_seq_gen.sv
// Streams the radix-2 FFT/IFFT twiddle sequence (stage by stage, butterfly by butterfly)
// from a quarter-wave cosine table, through a two-stage valid/ready pipeline.
module twiddle_seq_gen #(
  parameter int N_LOG2  = 5,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  localparam int STAGE_W = (N_LOG2 <= 2) ? 1 : $clog2(N_LOG2),
  localparam int IDX_W   = N_LOG2 - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               inv,
  output logic               busy,
  output logic               done,
  output logic               tw_valid,
  input  logic               tw_ready,
  output logic [DATA_W-1:0]  tw_re,
  output logic [DATA_W-1:0]  tw_im,
  output logic [STAGE_W-1:0] tw_stage,
  output logic [IDX_W-1:0]   tw_idx,
  output logic               tw_last
);

  localparam int  N       = 1 << N_LOG2;
  localparam int  QUARTER = 1 << (N_LOG2 - 2);
  localparam real PI      = 3.14159265358979323846;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;

  logic [STAGE_W-1:0] s_q;
  logic [IDX_W-1:0]   j_q;
  logic               inv_q;
  logic               en, issue, last_issue, accept;

  logic [IDX_W-1:0]   mask, k, cos_addr, sin_addr;
  logic [STAGE_W-1:0] sh;
  logic               neg;

  logic               s1_valid, s1_last, s1_neg;
  logic [STAGE_W-1:0] s1_stage;
  logic [IDX_W-1:0]   s1_idx;
  logic [DATA_W-1:0]  cos_q, sin_q;

  // Quarter-wave table, fully determined by the parameters at elaboration.
  logic [DATA_W-1:0] rom [0:QUARTER];
  for (genvar g = 0; g <= QUARTER; g++) begin : g_rom
    assign rom[g] = DATA_W'($rtoi($floor((2.0 ** FRAC_W) *
                                          $cos(2.0 * PI * real'(g) / real'(N)))));
  end

  assign en         = !tw_valid || tw_ready;
  assign accept     = tw_valid && tw_ready;
  assign busy       = (state_q != IDLE);
  assign last_issue = (s_q == STAGE_W'(N_LOG2 - 1)) && (j_q == '1);

  // Exponent k = (j mod 2^s) << (N_LOG2-1-s), then fold onto the quarter wave.
  always_comb begin
    mask     = IDX_W'((1 << s_q) - 1);
    sh       = STAGE_W'(N_LOG2 - 1) - s_q;
    k        = (j_q & mask) << sh;
    neg      = 1'b0;
    cos_addr = k;
    sin_addr = IDX_W'(QUARTER) - k;
    if (k > IDX_W'(QUARTER)) begin
      neg      = 1'b1;
      cos_addr = -k;  // N/2 - k: N/2 wraps to zero in IDX_W bits
      sin_addr = k - IDX_W'(QUARTER);
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        if (en) begin
          issue = 1'b1;
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: if (accept && tw_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: rst is synchronous, so it is tested inside the clocked branch and is not
  // in the sensitivity list; all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      j_q   <= '0;
      inv_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      s_q   <= '0;
      j_q   <= '0;
      inv_q <= inv;
    end else if (issue) begin
      j_q <= j_q + 1'b1;
      if (j_q == '1) s_q <= s_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_neg   <= 1'b0;
      s1_stage <= '0;
      s1_idx   <= '0;
      cos_q    <= '0;
      sin_q    <= '0;
      tw_valid <= 1'b0;
      tw_last  <= 1'b0;
      tw_stage <= '0;
      tw_idx   <= '0;
      tw_re    <= '0;
      tw_im    <= '0;
    end else if (en) begin
      s1_valid <= issue;
      s1_last  <= last_issue;
      s1_neg   <= neg;
      s1_stage <= s_q;
      s1_idx   <= j_q;
      cos_q    <= rom[cos_addr];
      sin_q    <= rom[sin_addr];
      tw_valid <= s1_valid;
      tw_last  <= s1_last;
      tw_stage <= s1_stage;
      tw_idx   <= s1_idx;
      tw_re    <= s1_neg ? -cos_q : cos_q;
      tw_im    <= inv_q ? sin_q : -sin_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= accept && tw_last;
  end

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Self-checking bench for twiddle_seq_gen: trigonometric reference model, spot-value
// table, random backpressure, long stall, mid-sequence reset and start-in-done restart.
module tb_twiddle_seq_gen;

  localparam int N_LOG2  = 5;
  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int N       = 1 << N_LOG2;
  localparam int HALF    = N / 2;
  localparam int QUARTER = N / 4;
  localparam int WORDS   = N_LOG2 * HALF;

  logic              clk = 1'b0;
  logic              rst, start, inv, tw_ready;
  logic              busy, done, tw_valid, tw_last;
  logic [DATA_W-1:0] tw_re, tw_im;
  logic [2:0]        tw_stage;
  logic [3:0]        tw_idx;

  twiddle_seq_gen #(.N_LOG2(N_LOG2), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv), .busy(busy), .done(done),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re), .tw_im(tw_im),
    .tw_stage(tw_stage), .tw_idx(tw_idx), .tw_last(tw_last)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int q [0:QUARTER];
  logic [15:0] cap_re [0:1][0:WORDS-1];
  logic [15:0] cap_im [0:1][0:WORDS-1];

  typedef struct {
    bit          inv_m;
    int          w;
    logic [15:0] re;
    logic [15:0] im;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Twiddle for word w: cos/sin of 2*pi*k/N read from the quarter-wave table by symmetry.
  function automatic void model(input int w, input bit inv_m, output logic [15:0] re,
                                output logic [15:0] im, output int st, output int ix);
    int s, j, k, c, sn;
    s  = w / HALF;
    j  = w % HALF;
    k  = (j % (1 << s)) * (1 << (N_LOG2 - 1 - s));
    c  = (k <= QUARTER) ? q[k] : -q[HALF - k];
    sn = (k <= QUARTER) ? q[QUARTER - k] : q[k - QUARTER];
    re = 16'(c);
    im = inv_m ? 16'(sn) : 16'(-sn);
    st = s;
    ix = j;
  endfunction

  // mode: 0 = always ready, 1 = random ready, 2 = 10-cycle stall at word 40
  task automatic run_seq(input bit inv_i, input int mode, input bit pre_started,
                         input bit poke_busy, input bit chain_next, input int abort_at,
                         input bit save);
    int          w, cyc, stall_cnt, first_cyc, st, ix;
    bit          held, fin, after_last, timed_out;
    logic [40:0] held_v;
    logic [15:0] e_re, e_im;
    w = 0; cyc = 0; stall_cnt = 0; first_cyc = -1;
    held = 0; fin = 0; after_last = 0; timed_out = 0; held_v = '0;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1; inv = inv_i; tw_ready = 1'b1;
    end
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc > 1000) begin
        check("seq_timeout", 64'(cyc), 64'd0);
        timed_out = 1;
        break;
      end
      if (cyc == 1) check("busy_rise", busy, 1);
      if (poke_busy && cyc == 20) begin
        start = 1'b1;
        inv   = ~inv_i;
      end
      if (held) check("stall_hold", {tw_valid, tw_last, tw_stage, tw_idx, tw_re, tw_im}, held_v);
      if (tw_valid && first_cyc < 0) first_cyc = cyc;
      if (after_last) begin
        check("done_pulse", {done, busy, tw_valid}, 3'b100);
        if (chain_next) begin
          start = 1'b1;
          inv   = inv_i;
        end else begin
          @(negedge clk);
          check("done_one_cycle", {done, tw_valid}, 2'b00);
        end
        fin = 1;
      end else begin
        check("no_early_done", done, 0);
        tw_ready = 1'b1;
        if (mode == 1) tw_ready = 1'($urandom_range(0, 1));
        if (mode == 2 && tw_valid && w == 40 && stall_cnt < 10) begin
          tw_ready = 1'b0;
          stall_cnt++;
          check("stall_pos", {tw_stage, tw_idx}, {3'd2, 4'd8});
        end
        if (tw_valid && tw_ready) begin
          model(w, inv_i, e_re, e_im, st, ix);
          check($sformatf("word%0d_inv%0d", w, inv_i),
                {tw_stage, tw_idx, tw_re, tw_im}, {3'(st), 4'(ix), e_re, e_im});
          check($sformatf("last%0d", w), tw_last, (w == WORDS - 1));
          if (save) begin
            cap_re[inv_i][w] = tw_re;
            cap_im[inv_i][w] = tw_im;
          end
          w++;
          if (w == WORDS) after_last = 1;
          if (abort_at >= 0 && w == abort_at) fin = 1;
        end
        held = tw_valid && !tw_ready;
        if (held) held_v = {tw_valid, tw_last, tw_stage, tw_idx, tw_re, tw_im};
      end
    end
    if (!timed_out) begin
      check("first_valid_latency", 64'(first_cyc), 64'd3);
      if (abort_at < 0) check("word_count", 64'(w), 64'(WORDS));
      if (mode == 2) check("stall_cycles", 64'(stall_cnt), 64'd10);
    end
  endtask

  initial begin
    for (int k = 0; k <= QUARTER; k++)
      q[k] = $rtoi($floor(256.0 * $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(N))));

    vecs[0] = '{1'b0, 0,  16'h0100, 16'h0000};
    vecs[1] = '{1'b0, 7,  16'h0100, 16'h0000};
    vecs[2] = '{1'b0, 15, 16'h0100, 16'h0000};
    vecs[3] = '{1'b0, 21, 16'h0000, 16'hFF00};
    vecs[4] = '{1'b0, 65, 16'h00FB, 16'hFFCF};
    vecs[5] = '{1'b0, 79, 16'hFF05, 16'hFFCF};
    vecs[6] = '{1'b1, 65, 16'h00FB, 16'h0031};
    vecs[7] = '{1'b1, 72, 16'h0000, 16'h0100};
    vecs[8] = '{1'b1, 76, 16'hFF4B, 16'h00B5};

    rst = 1'b1; start = 1'b0; inv = 1'b0; tw_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, tw_valid, tw_last, tw_re, tw_im, tw_stage, tw_idx}, '0);
    rst = 1'b0;

    run_seq(1'b0, 0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    run_seq(1'b1, 0, 1'b0, 1'b0, 1'b0, -1, 1'b1);

    for (int i = 0; i < 9; i++)
      check($sformatf("spot_w%0d_inv%0d", vecs[i].w, vecs[i].inv_m),
            {cap_re[vecs[i].inv_m][vecs[i].w], cap_im[vecs[i].inv_m][vecs[i].w]},
            {vecs[i].re, vecs[i].im});

    run_seq(1'b0, 1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_seq(1'b1, 1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_seq(1'b0, 2, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    // Reset in the middle of a sequence, then a fresh sequence.
    run_seq(1'b0, 0, 1'b0, 1'b0, 1'b0, 30, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1;
      check("reset_mid_seq", {busy, done, tw_valid, tw_last, tw_re, tw_im, tw_stage, tw_idx}, '0);
    end
    start = 1'b0;
    rst   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_quiet", {busy, done, tw_valid}, 3'b000);
    end
    run_seq(1'b0, 0, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    // Start while busy is ignored; start in the done cycle launches the next sequence.
    run_seq(1'b0, 0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    run_seq(1'b0, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
